// File: rtl/reorder_logic_sequencer.sv
// rtl/reorder_logic_sequencer.sv - in-order retire engine over round-robin response queues
module reorder_logic_sequencer #(
   parameter int NUM_QUEUES      = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 16,
   parameter int STALL_TIMEOUT   = 255,
   parameter int SEL_WIDTH       = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             flush_i,
   input  logic                             issue_i,
   output logic                             issue_rdy_o,
   output logic [SEL_WIDTH-1:0]             issue_sel_o,
   input  logic [NUM_QUEUES-1:0]            status_i,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] data_i,
   output logic [NUM_QUEUES-1:0]            ack_o,
   output logic                             out_valid_o,
   output logic [DATA_WIDTH-1:0]            out_data_o,
   input  logic                             out_ready_i,
   output logic [CNT_WIDTH-1:0]             outstanding_o,
   output logic                             stall_err_o
);

   // Counter wide enough to reach the timeout; one bit when the timeout is disabled.
   localparam int STALL_WIDTH = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam logic [SEL_WIDTH-1:0]   LAST_SEL    = SEL_WIDTH'(NUM_QUEUES - 1);
   localparam logic [CNT_WIDTH-1:0]   MAX_CNT     = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(STALL_TIMEOUT);

   logic [SEL_WIDTH-1:0]   issue_ptr_q, issue_ptr_d;
   logic [SEL_WIDTH-1:0]   retire_ptr_q, retire_ptr_d;
   logic [CNT_WIDTH-1:0]   outstanding_q, outstanding_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [STALL_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic                   stall_err_q, stall_err_d;
   logic [1:0]             state_q, state_d;

   logic                   head_valid;
   logic [DATA_WIDTH-1:0]  head_data;
   logic [NUM_QUEUES-1:0]  head_onehot;
   logic                   issue_rdy;
   logic                   issue_acc;
   logic                   out_free;
   logic                   can_pull;

   // Select the queue currently owed a retire (the oldest issued request).
   always_comb begin
      head_valid  = 1'b0;
      head_data   = '0;
      head_onehot = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         if (retire_ptr_q == SEL_WIDTH'(q)) begin
            head_valid     = status_i[q];
            head_data      = data_i[q*DATA_WIDTH +: DATA_WIDTH];
            head_onehot[q] = 1'b1;
         end
      end
   end

   // Accept/pull qualification; flush suppresses both so nothing moves that cycle.
   always_comb begin
      issue_rdy = (outstanding_q < MAX_CNT);
      issue_acc = issue_i & issue_rdy & ~flush_i;
      out_free  = ~out_valid_q | out_ready_i;
      can_pull  = (outstanding_q != '0) & head_valid & out_free & ~flush_i;
   end

   // Pointer, credit and output-stage next state.
   always_comb begin
      issue_ptr_d   = issue_ptr_q;
      retire_ptr_d  = retire_ptr_q;
      outstanding_d = outstanding_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;

      if (issue_acc) begin
         issue_ptr_d = (issue_ptr_q == LAST_SEL) ? '0 : issue_ptr_q + 1'b1;
      end

      if (can_pull) begin
         retire_ptr_d = (retire_ptr_q == LAST_SEL) ? '0 : retire_ptr_q + 1'b1;
         out_valid_d  = 1'b1;
         out_data_d   = head_data;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d  = 1'b0;
      end

      case ({issue_acc, can_pull})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   // Stall watchdog: only cycles spent waiting on an empty head count, not back-pressure.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (can_pull) begin
         stall_cnt_d = '0;
      end else if ((state_q == ST_WAIT) && !head_valid && (stall_cnt_q != STALL_LIMIT)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Retire FSM; the error flag latches on the WAIT->STALL transition only.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (issue_acc) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (outstanding_d == '0) begin
               state_d = ST_IDLE;
            end else if ((STALL_TIMEOUT != 0) && (stall_cnt_q == STALL_LIMIT) && !can_pull) begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (can_pull) begin
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      stall_err_d = stall_err_q | ((state_q == ST_WAIT) && (state_d == ST_STALL));
   end

   // State registers; flush clears exactly what reset clears.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         issue_ptr_q   <= '0;
         retire_ptr_q  <= '0;
         outstanding_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         stall_cnt_q   <= '0;
         stall_err_q   <= 1'b0;
         state_q       <= ST_IDLE;
      end else begin
         issue_ptr_q   <= issue_ptr_d;
         retire_ptr_q  <= retire_ptr_d;
         outstanding_q <= outstanding_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         stall_cnt_q   <= stall_cnt_d;
         stall_err_q   <= stall_err_d;
         state_q       <= state_d;
      end
   end

   assign issue_rdy_o   = issue_rdy;
   assign issue_sel_o   = issue_ptr_q;
   assign ack_o         = can_pull ? head_onehot : '0;
   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign outstanding_o = outstanding_q;
   assign stall_err_o   = stall_err_q;

endmodule

// File: tb/tb_reorder_logic_sequencer.sv
// tb/tb_reorder_logic_sequencer.sv - directed self-checking bench for reorder_logic_sequencer
module tb_reorder_logic_sequencer;

   logic clk, rst, flush;
   int checks, errors;

   // 4-queue instance, stall timeout 8
   logic         issue, issue_rdy, out_valid, out_ready, stall_err;
   logic [1:0]   issue_sel;
   logic [3:0]   status, ack;
   logic [127:0] data;
   logic [31:0]  out_data;
   logic [4:0]   outstanding;

   // 3-queue instance, stall timeout disabled
   logic         issue3, issue_rdy3, out_valid3, out_ready3, stall_err3;
   logic [1:0]   issue_sel3;
   logic [2:0]   status3, ack3;
   logic [95:0]  data3;
   logic [31:0]  out_data3;
   logic [4:0]   outstanding3;

   reorder_logic_sequencer #(.NUM_QUEUES(4), .DATA_WIDTH(32), .MAX_OUTSTANDING(16), .STALL_TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .issue_i(issue), .issue_rdy_o(issue_rdy),
      .issue_sel_o(issue_sel), .status_i(status), .data_i(data), .ack_o(ack),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
      .outstanding_o(outstanding), .stall_err_o(stall_err));

   reorder_logic_sequencer #(.NUM_QUEUES(3), .DATA_WIDTH(32), .MAX_OUTSTANDING(16), .STALL_TIMEOUT(0)) dut3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .issue_i(issue3), .issue_rdy_o(issue_rdy3),
      .issue_sel_o(issue_sel3), .status_i(status3), .data_i(data3), .ack_o(ack3),
      .out_valid_o(out_valid3), .out_data_o(out_data3), .out_ready_i(out_ready3),
      .outstanding_o(outstanding3), .stall_err_o(stall_err3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; issue = 1'b0; issue3 = 1'b0;
      status = '0; status3 = '0; out_ready = 1'b1; out_ready3 = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_data(input logic [31:0] base);
      for (int q = 0; q < 4; q++) data[q*32 +: 32] = base + 32'(q);
      for (int q = 0; q < 3; q++) data3[q*32 +: 32] = base + 32'(q);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; issue = 1'b0; issue3 = 1'b0;
      status = 4'hF; status3 = 3'h7; out_ready = 1'b1; out_ready3 = 1'b1;
      load_data(32'h1111_0000);
      tick();
      tick();
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b want %b", ack, 4'b0000); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
      checks++; if (issue_sel !== 2'd0) begin errors++; $display("FAIL rst_issue_sel got %0d want 0", issue_sel); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL rst_stall_err got %b want 0", stall_err); end
      checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL rst_issue_rdy got %b want 1", issue_rdy); end
      checks++; if (ack3 !== 3'b000) begin errors++; $display("FAIL rst_ack3 got %b want 000", ack3); end
      rst = 1'b0; status = '0; status3 = '0;
      tick();
   endtask

   task automatic test_out_of_order();
      do_reset();
      load_data(32'hC0DE_0000);
      issue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (issue_sel !== 2'(i)) begin errors++; $display("FAIL ooo_issue_sel%0d got %0d want %0d", i, issue_sel, i); end
         tick();
      end
      issue = 1'b0;
      checks++; if (outstanding !== 5'd4) begin errors++; $display("FAIL ooo_outstanding got %0d want 4", outstanding); end
      status = 4'b1000; #1;
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ooo_ack_q3_only got %b want 0000", ack); end
      tick();
      status = 4'b1010; #1;
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ooo_ack_q1q3 got %b want 0000", ack); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_valid got %b want 0", out_valid); end
      status = 4'b1011; #1;
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL ooo_ack0 got %b want 0001", ack); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hC0DE_0000) begin errors++; $display("FAIL ooo_data0 got %b/%h want 1/c0de0000", out_valid, out_data); end
      status = 4'b1010; #1;
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL ooo_ack1 got %b want 0010", ack); end
      tick();
      checks++; if (out_data !== 32'hC0DE_0001) begin errors++; $display("FAIL ooo_data1 got %h want c0de0001", out_data); end
      status = 4'b1000; #1;
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ooo_ack_wait2 got %b want 0000", ack); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained got %b want 0", out_valid); end
      status = 4'b1100; #1;
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL ooo_ack2 got %b want 0100", ack); end
      tick();
      checks++; if (out_data !== 32'hC0DE_0002) begin errors++; $display("FAIL ooo_data2 got %h want c0de0002", out_data); end
      status = 4'b1000; #1;
      checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL ooo_ack3 got %b want 1000", ack); end
      tick();
      checks++; if (out_data !== 32'hC0DE_0003) begin errors++; $display("FAIL ooo_data3 got %h want c0de0003", out_data); end
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL ooo_final_outstanding got %0d want 0", outstanding); end
      status = 4'b0000;
      tick();
   endtask

   task automatic test_back_pressure();
      int ack_count;
      do_reset();
      issue = 1'b1; tick(); tick(); issue = 1'b0;
      load_data(32'hBEEF_0000);
      status = 4'b0011; out_ready = 1'b0; #1;
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL bp_first_ack got %b want 0001", ack); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0000) begin errors++; $display("FAIL bp_first_data got %b/%h want 1/beef0000", out_valid, out_data); end
      status = 4'b0010;
      ack_count = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ack != 4'b0000) ack_count++;
         checks++; if (out_data !== 32'hBEEF_0000 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/beef0000", i, out_valid, out_data); end
         tick();
      end
      checks++; if (ack_count !== 0) begin errors++; $display("FAIL bp_extra_acks got %0d want 0", ack_count); end
      out_ready = 1'b1; #1;
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL bp_release_ack got %b want 0010", ack); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0001) begin errors++; $display("FAIL bp_second_data got %b/%h want 1/beef0001", out_valid, out_data); end
      status = 4'b0000;
      tick();
      checks++; if (out_valid !== 1'b0 || outstanding !== 5'd0) begin errors++; $display("FAIL bp_drain got %b/%0d want 0/0", out_valid, outstanding); end
   endtask

   task automatic test_credit_limit();
      do_reset();
      issue = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      issue = 1'b0;
      checks++; if (outstanding !== 5'd16 || issue_rdy !== 1'b0) begin errors++; $display("FAIL cr_full got %0d/%b want 16/0", outstanding, issue_rdy); end
      issue = 1'b1; tick(); issue = 1'b0;
      checks++; if (outstanding !== 5'd16 || issue_sel !== 2'd0) begin errors++; $display("FAIL cr_17th got %0d/%0d want 16/0", outstanding, issue_sel); end
      status = 4'b0001; #1;
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL cr_retire_ack got %b want 0001", ack); end
      tick();
      checks++; if (outstanding !== 5'd15) begin errors++; $display("FAIL cr_after_retire got %0d want 15", outstanding); end
      status = 4'b0010; issue = 1'b1; #1;
      checks++; if (issue_rdy !== 1'b1 || ack !== 4'b0010) begin errors++; $display("FAIL cr_both got %b/%b want 1/0010", issue_rdy, ack); end
      tick();
      checks++; if (outstanding !== 5'd15 || issue_sel !== 2'd1) begin errors++; $display("FAIL cr_both_count got %0d/%0d want 15/1", outstanding, issue_sel); end
      status = 4'b0000;
      tick();
      issue = 1'b0;
      checks++; if (outstanding !== 5'd16 || issue_rdy !== 1'b0) begin errors++; $display("FAIL cr_refill got %0d/%b want 16/0", outstanding, issue_rdy); end
   endtask

   task automatic test_wrap3();
      logic [2:0] one;
      logic [2:0] exp_ack;
      do_reset();
      load_data(32'hE000_0000);
      issue3 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checks++; if (issue_sel3 !== 2'(i % 3)) begin errors++; $display("FAIL wr_issue_sel%0d got %0d want %0d", i, issue_sel3, i % 3); end
         tick();
      end
      issue3 = 1'b0;
      checks++; if (outstanding3 !== 5'd7 || issue_sel3 !== 2'd1) begin errors++; $display("FAIL wr_issued got %0d/%0d want 7/1", outstanding3, issue_sel3); end
      repeat (20) tick();
      checks++; if (stall_err3 !== 1'b0) begin errors++; $display("FAIL wr_no_timeout got %b want 0", stall_err3); end
      one = 3'b001;
      for (int k = 0; k < 7; k++) begin
         exp_ack = one << (k % 3);
         status3 = exp_ack; #1;
         checks++; if (ack3 !== exp_ack) begin errors++; $display("FAIL wr_ack%0d got %b want %b", k, ack3, exp_ack); end
         tick();
         checks++; if (out_data3 !== 32'hE000_0000 + 32'(k % 3)) begin errors++; $display("FAIL wr_data%0d got %h want %h", k, out_data3, 32'hE000_0000 + 32'(k % 3)); end
         status3 = 3'b000;
      end
      checks++; if (outstanding3 !== 5'd0) begin errors++; $display("FAIL wr_final got %0d want 0", outstanding3); end
      tick();
   endtask

   task automatic test_timeout_flush();
      do_reset();
      load_data(32'h5A5A_0000);
      issue = 1'b1; tick(); issue = 1'b0;
      repeat (6) tick();
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", stall_err); end
      repeat (6) tick();
      checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", stall_err); end
      out_ready = 1'b0; status = 4'b0001; #1;
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL to_retire_ack got %b want 0001", ack); end
      tick();
      status = 4'b0000;
      checks++; if (stall_err !== 1'b1 || outstanding !== 5'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL to_sticky got %b/%0d/%b want 1/0/1", stall_err, outstanding, out_valid); end
      issue = 1'b1; tick();
      flush = 1'b1; status = 4'b1111; #1;
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL fl_ack got %b want 0000", ack); end
      tick();
      flush = 1'b0; issue = 1'b0; status = 4'b0000; out_ready = 1'b1;
      checks++; if (outstanding !== 5'd0 || issue_sel !== 2'd0 || issue_rdy !== 1'b1) begin errors++; $display("FAIL fl_ptrs got %0d/%0d/%b want 0/0/1", outstanding, issue_sel, issue_rdy); end
      checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || stall_err !== 1'b0) begin errors++; $display("FAIL fl_out got %b/%h/%b want 0/0/0", out_valid, out_data, stall_err); end
   endtask

   initial begin
      clk = 1'b0; checks = 0; errors = 0;
      rst = 1'b1; flush = 1'b0; issue = 1'b0; issue3 = 1'b0;
      status = '0; status3 = '0; data = '0; data3 = '0; out_ready = 1'b1; out_ready3 = 1'b1;
      test_reset();
      test_out_of_order();
      test_back_pressure();
      test_credit_limit();
      test_wrap3();
      test_timeout_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
